// File: rtl/riscv_memory_arbiter.sv
// Two-port arbiter in front of the CPU-side memory interface: fetch (p0) and load/store (p1).
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed p1 priority.
module riscv_memory_arbiter #(
  parameter int READ_LATENCY = 2  // must be >= 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] p0_addr_in,
  input  logic [31:0] p0_data_in,
  input  logic [2:0]  p0_size_in,
  input  logic        p0_we_in,
  input  logic        p0_re_in,
  output logic        p0_gnt_out,
  output logic        p0_rvalid_out,
  output logic [31:0] p0_rdata_out,
  input  logic [31:0] p1_addr_in,
  input  logic [31:0] p1_data_in,
  input  logic [2:0]  p1_size_in,
  input  logic        p1_we_in,
  input  logic        p1_re_in,
  output logic        p1_gnt_out,
  output logic        p1_rvalid_out,
  output logic [31:0] p1_rdata_out,
  output logic [31:0] cpu_addr_out,
  output logic [31:0] cpu_data_out,
  output logic [2:0]  cpu_size_out,
  output logic        cpu_write_enable_out,
  output logic        cpu_read_enable_out,
  input  logic [31:0] cpu_data_in,
  input  logic        drain_in,
  output logic        halted_out
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t                  state, state_nxt;
  logic                    req0, req1;
  logic                    gnt_en, gnt0, gnt1, gnt_rd;
  logic                    pending;
  logic [READ_LATENCY-1:0] trk_vld, trk_own;

  assign req0   = p0_we_in | p0_re_in;
  assign req1   = p1_we_in | p1_re_in;
  // Drain gates grants combinationally, so the cycle drain rises never grants.
  assign gnt_en = rst_n_in & (state == RUN) & ~drain_in;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_win;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      last_win <= 1'b0;
    else if (gnt0 | gnt1)
      last_win <= gnt1;
  end

  assign gnt1 = gnt_en & req1 & (~req0 | ~last_win);
  assign gnt0 = gnt_en & req0 & (~req1 | last_win);
`else
  assign gnt1 = gnt_en & req1;
  assign gnt0 = gnt_en & req0 & ~req1;
`endif

  assign p0_gnt_out = gnt0;
  assign p1_gnt_out = gnt1;

  always_comb begin
    cpu_addr_out         = '0;
    cpu_data_out         = '0;
    cpu_size_out         = '0;
    cpu_write_enable_out = 1'b0;
    cpu_read_enable_out  = 1'b0;
    if (gnt1) begin
      cpu_addr_out         = p1_addr_in;
      cpu_data_out         = p1_data_in;
      cpu_size_out         = p1_size_in;
      cpu_write_enable_out = p1_we_in;
      cpu_read_enable_out  = p1_re_in & ~p1_we_in;
    end else if (gnt0) begin
      cpu_addr_out         = p0_addr_in;
      cpu_data_out         = p0_data_in;
      cpu_size_out         = p0_size_in;
      cpu_write_enable_out = p0_we_in;
      cpu_read_enable_out  = p0_re_in & ~p0_we_in;
    end
  end

  assign gnt_rd = cpu_read_enable_out;

  // Read tracker: stage 0 takes this cycle's granted read, last stage is the response slot
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      trk_vld <= '0;
      trk_own <= '0;
    end else begin
      trk_vld <= {trk_vld[READ_LATENCY-2:0], gnt_rd};
      trk_own <= {trk_own[READ_LATENCY-2:0], gnt1};
    end
  end

  assign p0_rvalid_out = trk_vld[READ_LATENCY-1] & ~trk_own[READ_LATENCY-1];
  assign p1_rvalid_out = trk_vld[READ_LATENCY-1] &  trk_own[READ_LATENCY-1];
  assign p0_rdata_out  = {32{p0_rvalid_out}} & cpu_data_in;
  assign p1_rdata_out  = {32{p1_rvalid_out}} & cpu_data_in;

  // Entries that remain after this cycle's response retires; zero means the tracker
  // is empty from the next cycle on, which is when HALT is entered.
  assign pending = |trk_vld[READ_LATENCY-2:0];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (drain_in) state_nxt = pending ? DRAIN : HALT;
      DRAIN:   if (!drain_in) state_nxt = RUN;
               else if (!pending) state_nxt = HALT;
      HALT:    if (!drain_in) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign halted_out = (state == HALT);

endmodule

// File: tb/tb_riscv_memory_arbiter.sv
// Directed bench for riscv_memory_arbiter with a 2-cycle behavioural memory on cpu_data_in.
module tb_riscv_memory_arbiter;

  localparam logic [2:0] MASK_B = 3'b001;
  localparam logic [2:0] MASK_W = 3'b111;

  logic        clk_in, rst_n_in;
  logic [31:0] p0_addr_in, p0_data_in, p1_addr_in, p1_data_in;
  logic [2:0]  p0_size_in, p1_size_in;
  logic        p0_we_in, p0_re_in, p1_we_in, p1_re_in;
  logic        p0_gnt_out, p0_rvalid_out, p1_gnt_out, p1_rvalid_out;
  logic [31:0] p0_rdata_out, p1_rdata_out;
  logic [31:0] cpu_addr_out, cpu_data_out, cpu_data_in;
  logic [2:0]  cpu_size_out;
  logic        cpu_write_enable_out, cpu_read_enable_out;
  logic        drain_in, halted_out;
  logic [31:0] rd_p1, rd_p2;

  int n_vec = 0;
  int n_bad = 0;

  riscv_memory_arbiter dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .p0_addr_in(p0_addr_in), .p0_data_in(p0_data_in), .p0_size_in(p0_size_in),
    .p0_we_in(p0_we_in), .p0_re_in(p0_re_in), .p0_gnt_out(p0_gnt_out),
    .p0_rvalid_out(p0_rvalid_out), .p0_rdata_out(p0_rdata_out),
    .p1_addr_in(p1_addr_in), .p1_data_in(p1_data_in), .p1_size_in(p1_size_in),
    .p1_we_in(p1_we_in), .p1_re_in(p1_re_in), .p1_gnt_out(p1_gnt_out),
    .p1_rvalid_out(p1_rvalid_out), .p1_rdata_out(p1_rdata_out),
    .cpu_addr_out(cpu_addr_out), .cpu_data_out(cpu_data_out), .cpu_size_out(cpu_size_out),
    .cpu_write_enable_out(cpu_write_enable_out), .cpu_read_enable_out(cpu_read_enable_out),
    .cpu_data_in(cpu_data_in), .drain_in(drain_in), .halted_out(halted_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: captured mid-cycle, data visible two cycles after the grant
  always @(negedge clk_in) begin
    rd_p1 <= cpu_read_enable_out ? mem_word(cpu_addr_out) : 32'hDEAD_BEEF;
    rd_p2 <= rd_p1;
  end
  assign cpu_data_in = rd_p2;

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_p0(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] s);
    p0_we_in = we; p0_re_in = re; p0_addr_in = a; p0_data_in = d; p0_size_in = s;
  endtask

  task automatic set_p1(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] s);
    p1_we_in = we; p1_re_in = re; p1_addr_in = a; p1_data_in = d; p1_size_in = s;
  endtask

  task automatic do_reset();
    cyc();
    rst_n_in = 1'b0;
    cyc();
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    set_p0(1'b0, 1'b1, 32'h40, 32'h0, MASK_W);
    set_p1(1'b1, 1'b0, 32'h44, 32'h77, MASK_W);
    cyc(); #2;
    n_vec++; if ({p0_gnt_out, p1_gnt_out} !== 2'b00) begin n_bad++; $display("FAIL reset_gnt got=%b exp=00", {p0_gnt_out, p1_gnt_out}); end
    n_vec++; if ({cpu_write_enable_out, cpu_read_enable_out, cpu_size_out} !== 5'b0) begin n_bad++; $display("FAIL reset_cpu_ctl got=%b exp=0", {cpu_write_enable_out, cpu_read_enable_out, cpu_size_out}); end
    n_vec++; if ({cpu_addr_out, cpu_data_out} !== 64'h0) begin n_bad++; $display("FAIL reset_cpu_bus got=%h exp=0", {cpu_addr_out, cpu_data_out}); end
    n_vec++; if ({p0_rvalid_out, p1_rvalid_out, halted_out} !== 3'b000) begin n_bad++; $display("FAIL reset_status got=%b exp=000", {p0_rvalid_out, p1_rvalid_out, halted_out}); end
    set_p0(1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    set_p1(1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    cyc();
    rst_n_in = 1'b1;
    cyc(); cyc();
  endtask

  task automatic test_single_read();
    cyc();
    set_p0(1'b0, 1'b1, 32'h100, 32'h0, MASK_W);
    #2;
    n_vec++; if ({p0_gnt_out, p1_gnt_out} !== 2'b10) begin n_bad++; $display("FAIL single_gnt got=%b exp=10", {p0_gnt_out, p1_gnt_out}); end
    n_vec++; if ({cpu_read_enable_out, cpu_write_enable_out} !== 2'b10) begin n_bad++; $display("FAIL single_re_we got=%b exp=10", {cpu_read_enable_out, cpu_write_enable_out}); end
    n_vec++; if (cpu_addr_out !== 32'h100 || cpu_size_out !== MASK_W) begin n_bad++; $display("FAIL single_addr_size got=%h/%b exp=100/%b", cpu_addr_out, cpu_size_out, MASK_W); end
    cyc();
    set_p0(1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    #2;
    n_vec++; if (p0_rvalid_out !== 1'b0) begin n_bad++; $display("FAIL single_early_rvalid got=%b exp=0", p0_rvalid_out); end
    cyc(); #2;
    n_vec++; if (p0_rvalid_out !== 1'b1 || p0_rdata_out !== mem_word(32'h100)) begin n_bad++; $display("FAIL single_resp got=%b/%h exp=1/%h", p0_rvalid_out, p0_rdata_out, mem_word(32'h100)); end
    n_vec++; if (p1_rvalid_out !== 1'b0 || p1_rdata_out !== 32'h0) begin n_bad++; $display("FAIL single_other got=%b/%h exp=0/0", p1_rvalid_out, p1_rdata_out); end
    cyc(); #2;
    n_vec++; if (p0_rvalid_out !== 1'b0) begin n_bad++; $display("FAIL single_late_rvalid got=%b exp=0", p0_rvalid_out); end
  endtask

  task automatic test_conflict();
    logic exp1 [6];
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (k == 0) begin
        set_p0(1'b0, 1'b1, 32'h300, 32'h0, MASK_W);
        set_p1(1'b0, 1'b1, 32'h400, 32'h0, MASK_W);
      end
      #2;
`ifdef ARB_ROUND_ROBIN_EN
      exp1[k] = (k % 2 == 0);
`else
      exp1[k] = 1'b1;
`endif
      n_vec++; if ({p1_gnt_out, p0_gnt_out} !== {exp1[k], ~exp1[k]}) begin n_bad++; $display("FAIL conflict_gnt[%0d] got p1p0=%b exp=%b", k, {p1_gnt_out, p0_gnt_out}, {exp1[k], ~exp1[k]}); end
      n_vec++; if (cpu_addr_out !== (exp1[k] ? 32'h400 : 32'h300)) begin n_bad++; $display("FAIL conflict_addr[%0d] got=%h exp=%h", k, cpu_addr_out, exp1[k] ? 32'h400 : 32'h300); end
      if (k >= 2) begin
        n_vec++; if ({p1_rvalid_out, p0_rvalid_out} !== {exp1[k-2], ~exp1[k-2]}) begin n_bad++; $display("FAIL conflict_owner[%0d] got p1p0=%b exp=%b", k, {p1_rvalid_out, p0_rvalid_out}, {exp1[k-2], ~exp1[k-2]}); end
      end
    end
    cyc();
    set_p0(1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    set_p1(1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    cyc(); cyc(); cyc();
  endtask

  task automatic test_write_vs_read();
    cyc();
    set_p1(1'b1, 1'b0, 32'h103, 32'hAB, MASK_B);
    set_p0(1'b0, 1'b1, 32'h104, 32'h0, MASK_W);
    #2;
    n_vec++; if ({p1_gnt_out, p0_gnt_out} !== 2'b10) begin n_bad++; $display("FAIL sb_gnt got p1p0=%b exp=10", {p1_gnt_out, p0_gnt_out}); end
    n_vec++; if ({cpu_write_enable_out, cpu_read_enable_out} !== 2'b10 || cpu_size_out !== MASK_B) begin n_bad++; $display("FAIL sb_ctl got we/re=%b size=%b exp=10/%b", {cpu_write_enable_out, cpu_read_enable_out}, cpu_size_out, MASK_B); end
    n_vec++; if (cpu_addr_out !== 32'h103 || cpu_data_out !== 32'hAB) begin n_bad++; $display("FAIL sb_bus got=%h/%h exp=103/ab", cpu_addr_out, cpu_data_out); end
    cyc();
    set_p1(1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    #2;
    n_vec++; if ({p1_gnt_out, p0_gnt_out} !== 2'b01 || cpu_addr_out !== 32'h104 || cpu_read_enable_out !== 1'b1) begin n_bad++; $display("FAIL sb_next got p1p0=%b addr=%h re=%b exp=01/104/1", {p1_gnt_out, p0_gnt_out}, cpu_addr_out, cpu_read_enable_out); end
    cyc();
    set_p0(1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    #2;
    n_vec++; if ({p1_rvalid_out, p0_rvalid_out} !== 2'b00) begin n_bad++; $display("FAIL sb_no_resp got=%b exp=00", {p1_rvalid_out, p0_rvalid_out}); end
    cyc(); #2;
    n_vec++; if ({p1_rvalid_out, p0_rvalid_out} !== 2'b01 || p0_rdata_out !== mem_word(32'h104)) begin n_bad++; $display("FAIL sb_read_resp got=%b/%h exp=01/%h", {p1_rvalid_out, p0_rvalid_out}, p0_rdata_out, mem_word(32'h104)); end
  endtask

  task automatic test_we_re_both();
    cyc();
    set_p0(1'b1, 1'b1, 32'h120, 32'h55, MASK_W);
    #2;
    n_vec++; if (p0_gnt_out !== 1'b1 || {cpu_write_enable_out, cpu_read_enable_out} !== 2'b10 || cpu_data_out !== 32'h55) begin n_bad++; $display("FAIL both_is_write got gnt=%b we/re=%b data=%h exp=1/10/55", p0_gnt_out, {cpu_write_enable_out, cpu_read_enable_out}, cpu_data_out); end
    cyc();
    set_p0(1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    cyc(); #2;
    n_vec++; if ({p1_rvalid_out, p0_rvalid_out} !== 2'b00) begin n_bad++; $display("FAIL both_no_resp got=%b exp=00", {p1_rvalid_out, p0_rvalid_out}); end
    cyc(); #2;
    n_vec++; if ({p1_rvalid_out, p0_rvalid_out} !== 2'b00) begin n_bad++; $display("FAIL both_no_resp_late got=%b exp=00", {p1_rvalid_out, p0_rvalid_out}); end
  endtask

  task automatic test_back_to_back();
    cyc();
    set_p0(1'b0, 1'b1, 32'h500, 32'h0, MASK_W);
    #2;
    n_vec++; if (p0_gnt_out !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt0 got=%b exp=1", p0_gnt_out); end
    cyc();
    set_p0(1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    set_p1(1'b0, 1'b1, 32'h600, 32'h0, MASK_W);
    #2;
    n_vec++; if (p1_gnt_out !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt1 got=%b exp=1", p1_gnt_out); end
    cyc();
    set_p1(1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    set_p0(1'b0, 1'b1, 32'h504, 32'h0, MASK_W);
    #2;
    n_vec++; if (p0_gnt_out !== 1'b1 || p0_rvalid_out !== 1'b1 || p0_rdata_out !== mem_word(32'h500)) begin n_bad++; $display("FAIL b2b_c2 got gnt=%b rv=%b data=%h exp=1/1/%h", p0_gnt_out, p0_rvalid_out, p0_rdata_out, mem_word(32'h500)); end
    cyc();
    set_p0(1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    #2;
    n_vec++; if ({p1_rvalid_out, p0_rvalid_out} !== 2'b10 || p1_rdata_out !== mem_word(32'h600) || p0_rdata_out !== 32'h0) begin n_bad++; $display("FAIL b2b_c3 got=%b/%h/%h exp=10/%h/0", {p1_rvalid_out, p0_rvalid_out}, p1_rdata_out, p0_rdata_out, mem_word(32'h600)); end
    cyc(); #2;
    n_vec++; if ({p1_rvalid_out, p0_rvalid_out} !== 2'b01 || p0_rdata_out !== mem_word(32'h504)) begin n_bad++; $display("FAIL b2b_c4 got=%b/%h exp=01/%h", {p1_rvalid_out, p0_rvalid_out}, p0_rdata_out, mem_word(32'h504)); end
  endtask

  task automatic test_drain();
    cyc();
    set_p0(1'b0, 1'b1, 32'h200, 32'h0, MASK_W);
    cyc();
    set_p0(1'b0, 1'b1, 32'h204, 32'h0, MASK_W);
    cyc();
    set_p0(1'b0, 1'b1, 32'h208, 32'h0, MASK_W);
    drain_in = 1'b1;
    #2;
    n_vec++; if (p0_gnt_out !== 1'b0 || cpu_read_enable_out !== 1'b0) begin n_bad++; $display("FAIL drain_rise_gnt got=%b/%b exp=0/0", p0_gnt_out, cpu_read_enable_out); end
    n_vec++; if (p0_rvalid_out !== 1'b1 || p0_rdata_out !== mem_word(32'h200) || halted_out !== 1'b0) begin n_bad++; $display("FAIL drain_resp0 got=%b/%h/h%b exp=1/%h/h0", p0_rvalid_out, p0_rdata_out, halted_out, mem_word(32'h200)); end
    cyc(); #2;
    n_vec++; if (p0_gnt_out !== 1'b0 || p0_rvalid_out !== 1'b1 || p0_rdata_out !== mem_word(32'h204) || halted_out !== 1'b0) begin n_bad++; $display("FAIL drain_resp1 got=%b/%b/%h/h%b exp=0/1/%h/h0", p0_gnt_out, p0_rvalid_out, p0_rdata_out, halted_out, mem_word(32'h204)); end
    cyc(); #2;
    n_vec++; if (halted_out !== 1'b1 || p0_gnt_out !== 1'b0 || p0_rvalid_out !== 1'b0) begin n_bad++; $display("FAIL drain_halt got h=%b gnt=%b rv=%b exp=1/0/0", halted_out, p0_gnt_out, p0_rvalid_out); end
    cyc();
    drain_in = 1'b0;
    #2;
    n_vec++; if (halted_out !== 1'b1 || p0_gnt_out !== 1'b0) begin n_bad++; $display("FAIL drain_release got h=%b gnt=%b exp=1/0", halted_out, p0_gnt_out); end
    cyc(); #2;
    n_vec++; if (halted_out !== 1'b0 || p0_gnt_out !== 1'b1 || cpu_addr_out !== 32'h208) begin n_bad++; $display("FAIL drain_resume got h=%b gnt=%b addr=%h exp=0/1/208", halted_out, p0_gnt_out, cpu_addr_out); end
    cyc();
    set_p0(1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    cyc(); cyc(); cyc();
    drain_in = 1'b1;
    #2;
    n_vec++; if (halted_out !== 1'b0) begin n_bad++; $display("FAIL idle_drain_same got=%b exp=0", halted_out); end
    cyc(); #2;
    n_vec++; if (halted_out !== 1'b1) begin n_bad++; $display("FAIL idle_drain_halt got=%b exp=1", halted_out); end
    cyc();
    drain_in = 1'b0;
    cyc(); #2;
    n_vec++; if (halted_out !== 1'b0) begin n_bad++; $display("FAIL idle_drain_exit got=%b exp=0", halted_out); end
  endtask

  task automatic test_reset_inflight();
    cyc();
    set_p0(1'b0, 1'b1, 32'h700, 32'h0, MASK_W);
    cyc();
    set_p0(1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    set_p1(1'b0, 1'b1, 32'h704, 32'h0, MASK_W);
    cyc();
    rst_n_in = 1'b0;
    #1;
    n_vec++; if ({p0_rvalid_out, p1_rvalid_out, p1_gnt_out, cpu_read_enable_out} !== 4'b0 || p0_rdata_out !== 32'h0 || cpu_addr_out !== 32'h0) begin n_bad++; $display("FAIL rst_flight_now got=%b/%h/%h exp=0/0/0", {p0_rvalid_out, p1_rvalid_out, p1_gnt_out, cpu_read_enable_out}, p0_rdata_out, cpu_addr_out); end
    cyc();
    set_p1(1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    rst_n_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(); #2;
      n_vec++; if ({p0_rvalid_out, p1_rvalid_out} !== 2'b00) begin n_bad++; $display("FAIL rst_stale[%0d] got=%b exp=00", k, {p0_rvalid_out, p1_rvalid_out}); end
    end
  endtask

  initial begin
    drain_in = 1'b0;
    test_reset();
    test_single_read();
    test_conflict();
    test_write_vs_read();
    test_we_re_both();
    test_back_to_back();
    test_drain();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
